// File: rtl/lightboard_pkg.sv
// Shared lightboard pixel-link definitions, common to the transmit serializer and receive deserializer.
// Packet = 24-bit start address (MSB byte first) then a fixed run of 8-bit pixels, each byte sent LSB dibit first.
package lightboard_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RX_ADDR,
        RX_PIX,
        DRAIN
    } rx_state_t;

    localparam int ADDR_DIBITS       = 12;
    localparam int DIBITS_PER_BYTE   = 4;
    localparam int PIXELS_PER_PACKET = 320;
    localparam int ADDR_BYTES        = ADDR_DIBITS / DIBITS_PER_BYTE;

endpackage

// File: rtl/dibit_byte_assembler.sv
// Packs an LSB-first dibit stream into bytes.
// Latency: byte_vld_o/byte_o combinational on the 4th dibit; no backpressure, clear_i restarts byte alignment.
module dibit_byte_assembler (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       dibit_vld_i,
    input  logic [1:0] dibit_i,
    output logic       byte_vld_o,
    output logic [7:0] byte_o
);
    import lightboard_pkg::*;

    localparam logic [1:0] CNT_LAST = 2'(DIBITS_PER_BYTE - 1);

    logic [5:0] shift_q, shift_d;
    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            cnt_d = 2'd0;
        end else if (dibit_vld_i) begin
            // Newest dibit enters at the top, so the first one ends up in bits [1:0].
            shift_d = {dibit_i, shift_q[5:2]};
            cnt_d   = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign byte_vld_o = dibit_vld_i && !clear_i && (cnt_q == CNT_LAST);
    assign byte_o     = {dibit_i, shift_q};

endmodule

// File: rtl/pixel_stream_deserializer.sv
// Turns the dibit pixel-link stream into single-cycle frame-buffer writes; optional truncation stats under RX_TRUNC_CHECK_EN.
// Latency: write strobe one cycle after the dibit completing a pixel; no backpressure, BRAM must take every strobe.
module pixel_stream_deserializer #(
    parameter int PIXELS_PER_PACKET = lightboard_pkg::PIXELS_PER_PACKET,
    parameter int ADDR_WIDTH        = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  axiiv,
    input  logic [1:0]            axiid,
    output logic                  pixel_wr_en,
    output logic [ADDR_WIDTH-1:0] pixel_wr_addr,
    output logic [7:0]            pixel_wr_data,
    output logic                  packet_done,
    output logic                  rx_err,
    output logic [7:0]            err_count
);
    import lightboard_pkg::*;

    localparam int              PIX_W     = (PIXELS_PER_PACKET > 1) ? $clog2(PIXELS_PER_PACKET) : 1;
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS_PER_PACKET - 1);
    localparam logic [1:0]       ADDR_LAST = 2'(ADDR_BYTES - 1);

    rx_state_t              state_q;
    logic [1:0]             addr_byte_q;
    logic [ADDR_WIDTH-1:0]  addr_sh_q;
    logic [ADDR_WIDTH-1:0]  addr_d;
    logic [ADDR_WIDTH-1:0]  wr_ptr_q;
    logic [PIX_W-1:0]       pix_cnt_q;
    logic                   wr_en_q;
    logic [ADDR_WIDTH-1:0]  wr_addr_q;
    logic [7:0]             wr_data_q;
    logic                   done_q;

    logic       asm_vld;
    logic       asm_clear;
    logic       asm_byte_vld;
    logic [7:0] asm_byte;

    // Dropping axiiv or entering DRAIN realigns the assembler for the next packet.
    assign asm_vld   = axiiv && (state_q != DRAIN);
    assign asm_clear = !axiiv || (state_q == DRAIN);

    dibit_byte_assembler u_asm (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (asm_clear),
        .dibit_vld_i (asm_vld),
        .dibit_i     (axiid),
        .byte_vld_o  (asm_byte_vld),
        .byte_o      (asm_byte)
    );

    // Upper address bits fall off the top of the shift, leaving base = addr[ADDR_WIDTH-1:0].
    always_comb begin
        addr_d = (addr_sh_q << 8) | ADDR_WIDTH'(asm_byte);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_byte_q <= '0;
            addr_sh_q   <= '0;
            wr_ptr_q    <= '0;
            pix_cnt_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (axiiv) begin
                        state_q     <= RX_ADDR;
                        addr_byte_q <= '0;
                        pix_cnt_q   <= '0;
                    end
                end
                RX_ADDR: begin
                    if (!axiiv) begin
                        state_q <= IDLE;
                    end else if (asm_byte_vld) begin
                        addr_sh_q <= addr_d;
                        if (addr_byte_q == ADDR_LAST) begin
                            wr_ptr_q <= addr_d;
                            state_q  <= RX_PIX;
                        end else begin
                            addr_byte_q <= addr_byte_q + 2'd1;
                        end
                    end
                end
                RX_PIX: begin
                    if (!axiiv) begin
                        state_q <= IDLE;
                    end else if (asm_byte_vld) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= wr_ptr_q;
                        wr_data_q <= asm_byte;
                        wr_ptr_q  <= wr_ptr_q + ADDR_WIDTH'(1);
                        if (pix_cnt_q == PIX_LAST) begin
                            done_q  <= 1'b1;
                            state_q <= DRAIN;
                        end else begin
                            pix_cnt_q <= pix_cnt_q + PIX_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (!axiiv) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pixel_wr_en   = wr_en_q;
    assign pixel_wr_addr = wr_addr_q;
    assign pixel_wr_data = wr_data_q;
    assign packet_done   = done_q;

`ifdef RX_TRUNC_CHECK_EN
    logic       abort;
    logic       rx_err_q;
    logic [7:0] err_cnt_q;

    assign abort = !axiiv && ((state_q == RX_ADDR) || (state_q == RX_PIX));

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_err_q  <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            rx_err_q <= abort;
            if (abort && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign rx_err    = rx_err_q;
    assign err_count = err_cnt_q;
`else
    assign rx_err    = 1'b0;
    assign err_count = 8'd0;
`endif

endmodule
